// File: rtl/register_bank_reader_if.sv
// Bus bundle for register_bank_reader: command, bank read port, vector output.
// The bcast input exists only when REG_BANK_READER_BCAST_EN is defined.
interface register_bank_reader_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int MAX_LEN = 8
);
  logic                      start;
  logic [ADDR_W-1:0]         base_addr;
  logic [ADDR_W:0]           len;
`ifdef REG_BANK_READER_BCAST_EN
  logic                      bcast;
`endif
  logic                      busy;
  logic                      err;
  logic [ADDR_W-1:0]         dir_A;
  logic                      signal_read;
  logic [DATA_W-1:0]         eA;
  logic [DATA_W*MAX_LEN-1:0] vec_out;
  logic                      vec_valid;
  logic                      vec_ready;

  modport master (
    input  start, base_addr, len,
`ifdef REG_BANK_READER_BCAST_EN
    input  bcast,
`endif
    input  eA, vec_ready,
    output busy, err, dir_A, signal_read,
    output vec_out, vec_valid
  );

  modport slave (
    output start, base_addr, len,
`ifdef REG_BANK_READER_BCAST_EN
    output bcast,
`endif
    output eA, vec_ready,
    input  busy, err, dir_A, signal_read,
    input  vec_out, vec_valid
  );
endinterface

// File: rtl/register_bank_reader.sv
// Burst reader for the vector register bank; packs eA bytes into vec_out.
// Optional broadcast mode (single read replicated) via REG_BANK_READER_BCAST_EN.
module register_bank_reader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int MAX_LEN = 8,
  parameter int RD_LAT  = 1
) (
  input logic clk,
  input logic rst_n,
  register_bank_reader_if.master bus
);
  localparam int LW = ADDR_W + 1;
  localparam int VW = DATA_W * MAX_LEN;
  localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, HOLD
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] iss_q, iss_d;
  logic [LW-1:0] ret_q, ret_d;
  logic [LW-1:0] lane_q, lane_d;
  logic rd_q, rd_d;
  logic err_q, err_d;
  logic bc_q, bc_d;
  logic [VW-1:0] vec_q, vec_d;

  logic cap_v;
  logic [LW-1:0] cap_l;
  logic [LW-1:0] n_iss;
  logic last_cap;
  logic legal;
  logic bc_in;

`ifdef REG_BANK_READER_BCAST_EN
  assign bc_in = bus.bcast;
`else
  assign bc_in = 1'b0;
`endif

  // Outstanding requests: valid bit plus lane index, RD_LAT stages deep
  if (RD_LAT == 0) begin : g_lat0
    assign cap_v = rd_q;
    assign cap_l = lane_q;
  end else begin : g_pipe
    logic [RD_LAT-1:0] pv_q;
    logic [LW-1:0]     pl_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        for (int j = 0; j < RD_LAT; j++)
          pl_q[j] <= '0;
      end else begin
        pv_q[0] <= rd_q;
        pl_q[0] <= lane_q;
        for (int j = 1; j < RD_LAT; j++) begin
          pv_q[j] <= pv_q[j-1];
          pl_q[j] <= pl_q[j-1];
        end
      end
    end

    assign cap_v = pv_q[RD_LAT-1];
    assign cap_l = pl_q[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      dir_q   <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      lane_q  <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      bc_q    <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      bc_q    <= bc_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    dir_d    = dir_q;
    len_d    = len_q;
    iss_d    = iss_q;
    ret_d    = ret_q;
    lane_d   = lane_q;
    rd_d     = 1'b0;
    err_d    = 1'b0;
    bc_d     = bc_q;
    vec_d    = vec_q;
    legal    = (bus.len != '0) && (bus.len <= MAXL);
    n_iss    = bc_q ? LW'(1) : len_q;
    last_cap = cap_v && (ret_q == n_iss - 1'b1);

    if (cap_v && (state_q == ISSUE || state_q == DRAIN)) begin
      ret_d = ret_q + 1'b1;
      if (bc_q) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (LW'(i) < len_q)
            vec_d[i*DATA_W +: DATA_W] = bus.eA;
      end else begin
        vec_d[cap_l*DATA_W +: DATA_W] = bus.eA;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_d = ISSUE;
            base_d  = bus.base_addr;
            len_d   = bus.len;
            bc_d    = bc_in;
            iss_d   = '0;
            ret_d   = '0;
            vec_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (iss_q < n_iss) begin
          rd_d   = 1'b1;
          dir_d  = base_q + iss_q[ADDR_W-1:0];
          lane_d = iss_q;
          iss_d  = iss_q + 1'b1;
        end else if (last_cap) begin
          state_d = HOLD;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_cap)
          state_d = HOLD;
      end
      HOLD: begin
        if (bus.vec_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.err         = err_q;
  assign bus.dir_A       = dir_q;
  assign bus.signal_read = rd_q;
  assign bus.vec_out     = vec_q;
  assign bus.vec_valid   = (state_q == HOLD);
endmodule

// File: tb/tb_register_bank_reader.sv
// Scoreboard bench for register_bank_reader with a behavioural bank model.
// Stimulus pushes expected addresses/vectors; monitors pop and compare.
module tb_register_bank_reader;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int ML = 8;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_bank_reader_if #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML)
  ) bus ();

  register_bank_reader #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML), .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int pcyc = 0;
  int rmode = 0;
  logic [DW-1:0] mem [8];
  logic [DW*ML-1:0] exp_vec [$];
  int exp_cyc [$];
  logic [AW-1:0] exp_addr [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) pcyc <= pcyc + 1;

  // Bank with one cycle read latency; garbage when not reading
  always @(posedge clk) begin
    if (bus.signal_read) bus.eA <= mem[bus.dir_A];
    else bus.eA <= DW'($urandom);
  end

  function automatic logic [DW*ML-1:0] model(int base, int len, bit bc);
    logic [DW*ML-1:0] v;
    v = '0;
    for (int i = 0; i < len; i++)
      v[i*DW +: DW] = bc ? mem[base % 8] : mem[(base + i) % 8];
    return v;
  endfunction

  // Address monitor
  always @(negedge clk) begin
    if (rst_n && bus.signal_read) begin
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got addr %0d expected no read",
                 bus.dir_A);
      end else begin
        chk("dir_A", 64'(bus.dir_A), 64'(exp_addr.pop_front()));
      end
    end
  end

  // Vector monitor; also acts as the consumer driving vec_ready
  bit hs_prev = 0;
  bit have_cur = 0;
  int vcnt = 0;
  logic [DW*ML-1:0] cur_vec = '0;
  logic [DW*ML-1:0] last_vec = '0;

  always @(negedge clk) begin
    bit r;
    if (!rst_n) begin
      hs_prev = 0;
      have_cur = 0;
      bus.vec_ready = 1'b0;
    end else if (hs_prev) begin
      hs_prev = 0;
      chk("valid_drop", 64'(bus.vec_valid), 64'd0);
      chk("busy_drop", 64'(bus.busy), 64'd0);
      chk("vec_keep", bus.vec_out, last_vec);
      bus.vec_ready = 1'($urandom_range(0, 1));
    end else if (bus.vec_valid) begin
      if (!have_cur) begin
        if (exp_vec.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_vec: got %h expected none", bus.vec_out);
          cur_vec = '0;
        end else begin
          cur_vec = exp_vec.pop_front();
          chk("valid_cycle", 64'(pcyc), 64'(exp_cyc.pop_front()));
        end
        have_cur = 1;
        vcnt = 0;
      end
      chk("vec_out", bus.vec_out, cur_vec);
      chk("busy_hold", 64'(bus.busy), 64'd1);
      vcnt++;
      case (rmode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: r = (vcnt > 5);
      endcase
      bus.vec_ready = r;
      if (r) begin
        hs_prev = 1;
        have_cur = 0;
        last_vec = cur_vec;
      end
    end else begin
      bus.vec_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_idle(bit junk);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      bus.start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.base_addr = AW'($urandom);
      bus.len = (AW+1)'($urandom);
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        break;
      end
    end
  endtask

  task automatic burst(int base, int len, bit bc, bit junk);
    bit legal;
    wait_idle(junk);
    legal = (len >= 1) && (len <= ML);
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.len = (AW+1)'(len);
`ifdef REG_BANK_READER_BCAST_EN
    bus.bcast = bc;
`endif
    if (legal) begin
      for (int i = 0; i < (bc ? 1 : len); i++)
        exp_addr.push_back(AW'((base + i) % 8));
    end
    @(negedge clk);
    bus.start = 1'b0;
`ifdef REG_BANK_READER_BCAST_EN
    bus.bcast = 1'b0;
`endif
    if (legal) begin
      exp_vec.push_back(model(base, len, bc));
      exp_cyc.push_back(pcyc + (bc ? 1 : len) + RL + 1);
      chk("err_legal", 64'(bus.err), 64'd0);
    end else begin
      chk("err_pulse", 64'(bus.err), 64'd1);
      chk("illegal_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("err_clear", 64'(bus.err), 64'd0);
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.eA = '0;
    bus.vec_ready = 1'b0;
`ifdef REG_BANK_READER_BCAST_EN
    bus.bcast = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mem[i] = DW'(i + 'h10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_idle",
          {60'd0, bus.dir_A == 0, bus.signal_read,
           bus.vec_valid, bus.busy},
          {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    chk("rst_vec", bus.vec_out, 64'd0);

    rmode = 0;
    burst(2, 3, 0, 0);
    burst(6, 4, 0, 0);
    rmode = 2;
    burst(1, 5, 0, 0);
    burst(3, 0, 0, 1);
    rmode = 0;
    burst(3, 9, 0, 0);

    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    rmode = 1;
    for (int k = 0; k < 40; k++)
      burst($urandom_range(0, 7), $urandom_range(0, 11), 0, 1);

`ifdef REG_BANK_READER_BCAST_EN
    rmode = 0;
    burst(5, 4, 1, 0);
    burst(2, 8, 1, 0);
`endif

    wait_idle(0);
    for (int i = 0; i < 8; i++) mem[i] = DW'(i + 'h10);
    rmode = 0;
    bus.start = 1'b1;
    bus.base_addr = '0;
    bus.len = 4'd8;
    for (int i = 0; i < 8; i++) exp_addr.push_back(AW'(i));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rd", 64'(bus.signal_read), 64'd0);
    chk("abort_dir", 64'(bus.dir_A), 64'd0);
    chk("abort_valid", 64'(bus.vec_valid), 64'd0);
    chk("abort_vec", bus.vec_out, 64'd0);
    exp_addr.delete();
    exp_vec.delete();
    exp_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    burst(0, 2, 0, 0);
    chk("post_rst_model", model(0, 2, 0), 64'h1110);

    n = 0;
    while ((exp_vec.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_vec.size());
    end
    repeat (3) @(negedge clk);
    chk("addr_left", 64'(exp_addr.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_bank_reader.md
Name: register_bank_reader

Overview:
- Read-side sequencer for the 8-entry vector register bank.
- On a start command it issues a burst of consecutive read requests (dir_A / signal_read) to the bank and collects the returned eA bytes.
- Packs the bytes into one wide vector and hands it to the vector datapath over a valid/ready handshake.
- It is the reader counterpart of the bank's write port (dir_esc / data / signal_esc).

Parameters:
- DATA_W, 8, width of one register / eA.
- ADDR_W, 3, bank address width; the bank depth is 2**ADDR_W.
- MAX_LEN, 8, maximum lanes per burst; vec_out is DATA_W*MAX_LEN bits wide.
- RD_LAT, 1, bank read latency in cycles (legal 0..2). 0 means eA is combinational from dir_A.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- base_addr  input  ADDR_W  first register address.
- len  input  ADDR_W+1  lanes to read, legal 1..MAX_LEN.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on an illegal len.
- dir_A  output  ADDR_W  bank read address (registered).
- signal_read  output  1  bank read strobe (registered).
- eA  input  DATA_W  bank read data.
- vec_out  output  DATA_W*MAX_LEN  packed result; lane i is at bits [i*DATA_W +: DATA_W].
- vec_valid  output  1  result available.
- vec_ready  input  1  consumer accepts the result.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: busy=0, err=0, dir_A=0, signal_read=0, vec_out=0, vec_valid=0. FSM=IDLE; issue counter, return counter and in-flight pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE, legal start: start=1 with 1<=len<=MAX_LEN. Latch base_addr and len, clear vec_out to 0, go to ISSUE.
- IDLE, illegal start: start=1 with len=0 or len>MAX_LEN. err=1 for exactly the next cycle, no reads issued, stay IDLE.
- ISSUE: one request per cycle for len cycles. Request i drives signal_read=1 and dir_A=(base+i) mod 2**ADDR_W; the address wraps, e.g. base 6, len 4 reads 6,7,0,1. After the last request, signal_read=0 and the FSM goes to DRAIN. With RD_LAT=0 it goes straight to HOLD.
- Data return: eA for the request issued in cycle k is valid in cycle k+RD_LAT and is captured into lane i at the end of that cycle. An in-flight shift register of RD_LAT stages, each holding a valid bit and a lane index, tracks outstanding requests.
- DRAIN: wait until all len lanes are captured, then go to HOLD.
- HOLD: vec_valid=1 and vec_out stable. Lanes >= len read as 0.
- Handshake: the transfer completes in the cycle where vec_valid and vec_ready are both 1. Next cycle: vec_valid=0, FSM back in IDLE, vec_out keeps its value until the next accepted start. vec_ready while not valid is ignored.
- Latency: start sampled at edge E0 → first request in cycle E0+1 → vec_valid in cycle E0+len+RD_LAT+1.
- start while busy is ignored with no error. A start in the same cycle as the handshake is also ignored; a new burst needs IDLE.
- Reset mid-burst: all state aborts immediately and outputs return to reset values. Late eA values are discarded.
- dir_A holds its last value when signal_read=0.

Optional Feature:
- Macro: REG_BANK_READER_BCAST_EN.
- Defined: adds input port bcast (1 bit), sampled with start. With bcast=1 only base_addr is read (a single request), and the returned byte is replicated into lanes 0..len-1. vec_valid rises in cycle E0+1+RD_LAT+1. With bcast=0 the behaviour is normal.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset release, no start: dir_A=0, signal_read=0, vec_valid=0, busy=0 held for 20 cycles.
- Bank model preloaded reg[n]=n+0x10, RD_LAT=1, start with base=2, len=3 → read addresses 2,3,4 in three consecutive cycles; vec_valid in cycle E0+5; vec_out lanes0..2 = 0x12,0x13,0x14, others 0.
- Wrap: base=6, len=4 → dir_A sequence 6,7,0,1; lanes = 0x16,0x17,0x10,0x11.
- Backpressure: vec_ready=0 for 5 cycles after vec_valid → vec_out stable and start pulses ignored. vec_ready=1 → vec_valid drops next cycle and busy=0.
- Illegal len=0 and len=9 → err high exactly one cycle each, signal_read never asserted.
- rst_n pulsed low during ISSUE of a len=8 burst → outputs at reset values immediately. A new burst base=0, len=2 completes correctly with lanes 0x10,0x11. With REG_BANK_READER_BCAST_EN defined: bcast=1, base=5, len=4 → single read of address 5; lanes0..3 = 0x15.
